instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/udlx_pkg.sv | 15 +
 rtl/instruction_fetch_if.sv | 25 ++
 rtl/fetch_skid_buffer.sv | 34 +++
 rtl/instruction_fetch.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/udlx_pkg.sv
// Pipeline-wide constants and shared types for the udlx core.
// Fetch FSM encoding and the sequential PC step live here so later stages agree on them.
package udlx_pkg;

    localparam int PC_INCREMENT      = 4;
    localparam int INSTRUCTION_BYTES = 4;
    localparam int FETCH_STATE_BITS  = 2;

    typedef enum logic [FETCH_STATE_BITS-1:0] {
        S_REQ   = 2'd0,
        S_DROP  = 2'd1,
        S_STALL = 2'd2
    } fetch_state_t;

endpackage : udlx_pkg

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: request/address out, ack/data back.
// Latency: ack may be same cycle as req or later. Backpressure: req is held until ack.
interface instruction_fetch_if #(
    parameter int PC_WIDTH          = 32,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         inst_mem_req_out;
    logic [PC_WIDTH-1:0]          inst_mem_addr_out;
    logic                         inst_mem_ack_in;
    logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in;

    modport master (
        output inst_mem_req_out,
        output inst_mem_addr_out,
        input  inst_mem_ack_in,
        input  inst_mem_data_in
    );

    modport slave (
        input  inst_mem_req_out,
        input  inst_mem_addr_out,
        output inst_mem_ack_in,
        output inst_mem_data_in
    );
endinterface : instruction_fetch_if

// File: rtl/fetch_skid_buffer.sv
// One-entry hold buffer for a fetched word and its PC+4 while decode is stalled.
// Latency: 1 cycle load-to-visible. Backpressure: none; clear wins over load.
module fetch_skid_buffer #(
    parameter int PC_WIDTH          = 32,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         clear,
    input  logic [INSTRUCTION_WIDTH-1:0] load_data,
    input  logic [PC_WIDTH-1:0]          load_pc,
    output logic [INSTRUCTION_WIDTH-1:0] held_data,
    output logic [PC_WIDTH-1:0]          held_pc,
    output logic                         held_valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_data  <= '0;
            held_pc    <= '0;
            held_valid <= 1'b0;
        end else if (clear) begin
            held_data  <= '0;
            held_pc    <= '0;
            held_valid <= 1'b0;
        end else if (load) begin
            held_data  <= load_data;
            held_pc    <= load_pc;
            held_valid <= 1'b1;
        end
    end

endmodule : fetch_skid_buffer

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, memory request FSM and decode-facing output register.
// Latency: 1 cycle ack-to-output; zero-wait memory gives one instruction per cycle.
// Backpressure: en=0 parks one fetched word in the hold buffer and stops requesting.
module instruction_fetch
    import udlx_pkg::*;
#(
    parameter int                  PC_WIDTH          = 32,
    parameter int                  INSTRUCTION_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] PC_RESET          = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         select_new_pc_in,
    input  logic [PC_WIDTH-1:0]          new_pc_in,
    instruction_fetch_if.master          mem,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]          new_pc_out,
    output logic                         inst_valid_out
);

    fetch_state_t                 state;
    fetch_state_t                 state_nxt;
    logic [PC_WIDTH-1:0]          pc;
    logic [PC_WIDTH-1:0]          pc_nxt;
    logic [PC_WIDTH-1:0]          pc_inc;
    logic [INSTRUCTION_WIDTH-1:0] instr_nxt;
    logic [PC_WIDTH-1:0]          npc_nxt;
    logic                         valid_nxt;
    logic                         req;

    logic                         buf_load;
    logic                         buf_clear;
    logic [INSTRUCTION_WIDTH-1:0] buf_data;
    logic [PC_WIDTH-1:0]          buf_pc;
    logic                         buf_valid;

    // Wraps naturally modulo 2^PC_WIDTH.
    assign pc_inc = pc + PC_WIDTH'(PC_INCREMENT);

    assign mem.inst_mem_req_out  = req;
    assign mem.inst_mem_addr_out = pc;

    fetch_skid_buffer #(
        .PC_WIDTH          (PC_WIDTH),
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_data  (mem.inst_mem_data_in),
        .load_pc    (pc_inc),
        .held_data  (buf_data),
        .held_pc    (buf_pc),
        .held_valid (buf_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instruction_out;
        npc_nxt   = new_pc_out;
        valid_nxt = inst_valid_out;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        req       = 1'b0;

        unique case (state)
            S_REQ: begin
                req = 1'b1;
                if (select_new_pc_in) begin
                    pc_nxt    = new_pc_in;
                    valid_nxt = 1'b0;
                    buf_clear = 1'b1;
                    // An unanswered request must have its late response swallowed.
                    state_nxt = mem.inst_mem_ack_in ? S_REQ : S_DROP;
                end else if (mem.inst_mem_ack_in) begin
                    pc_nxt = pc_inc;
                    if (en) begin
                        instr_nxt = mem.inst_mem_data_in;
                        npc_nxt   = pc_inc;
                        valid_nxt = 1'b1;
                    end else begin
                        buf_load  = 1'b1;
                        state_nxt = S_STALL;
                    end
                end else if (en) begin
                    valid_nxt = 1'b0;
                end
            end

            S_STALL: begin
                if (select_new_pc_in) begin
                    pc_nxt    = new_pc_in;
                    valid_nxt = 1'b0;
                    buf_clear = 1'b1;
                    state_nxt = S_REQ;
                end else if (en) begin
                    instr_nxt = buf_data;
                    npc_nxt   = buf_pc;
                    valid_nxt = buf_valid;
                    buf_clear = 1'b1;
                    state_nxt = S_REQ;
                end
            end

            S_DROP: begin
                if (select_new_pc_in) begin
                    pc_nxt = new_pc_in;
                end
                if (mem.inst_mem_ack_in) begin
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc              <= PC_RESET;
            instruction_out <= '0;
            new_pc_out      <= '0;
            inst_valid_out  <= 1'b0;
        end else begin
            pc              <= pc_nxt;
            instruction_out <= instr_nxt;
            new_pc_out      <= npc_nxt;
            inst_valid_out  <= valid_nxt;
        end
    end

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: two instances (PC_RESET 0 and 0x200) share control inputs.
module tb_instruction_fetch;
    import udlx_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        select_new_pc;
    logic [31:0] new_pc;

    logic [31:0] instr_a, npc_a, instr_b, npc_b;
    logic        valid_a, valid_b;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_if #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(32)) mem_a ();
    instruction_fetch_if #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(32)) mem_b ();

    instruction_fetch #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(32), .PC_RESET(32'h0)) dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .select_new_pc_in (select_new_pc),
        .new_pc_in        (new_pc),
        .mem              (mem_a),
        .instruction_out  (instr_a),
        .new_pc_out       (npc_a),
        .inst_valid_out   (valid_a)
    );

    instruction_fetch #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(32), .PC_RESET(32'h200)) dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .select_new_pc_in (select_new_pc),
        .new_pc_in        (new_pc),
        .mem              (mem_b),
        .instruction_out  (instr_b),
        .new_pc_out       (npc_b),
        .inst_valid_out   (valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        en            = 1'b1;
        select_new_pc = 1'b0;
        new_pc        = '0;
        mem_a.inst_mem_ack_in  = 1'b0;
        mem_a.inst_mem_data_in = '0;
        mem_b.inst_mem_ack_in  = 1'b0;
        mem_b.inst_mem_data_in = '0;

        step();
        step();
        chk("rst_valid", valid_a, 0);
        chk("rst_instr", instr_a, 0);
        chk("rst_npc", npc_a, 0);
        chk("rst_req", mem_a.inst_mem_req_out, 1);
        chk("rst_addr", mem_a.inst_mem_addr_out, 0);
        chk("rst_b_addr", mem_b.inst_mem_addr_out, 32'h200);

        // Zero-wait streaming from PC 0.
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stream_addr", mem_a.inst_mem_addr_out, 32'(4 * i));
            chk("stream_req", mem_a.inst_mem_req_out, 1);
            if (i > 0) begin
                chk("stream_valid", valid_a, 1);
                chk("stream_npc", npc_a, 32'(4 * i));
                chk("stream_instr", instr_a, 32'hA000_0000 + 32'(4 * (i - 1)));
            end
            mem_a.inst_mem_ack_in  = 1'b1;
            mem_a.inst_mem_data_in = 32'hA000_0000 + 32'(4 * i);
            step();
        end
        chk("stream_last_valid", valid_a, 1);
        chk("stream_last_npc", npc_a, 32'h10);
        chk("stream_last_instr", instr_a, 32'hA000_000C);
        chk("stream_next_addr", mem_a.inst_mem_addr_out, 32'h10);

        mem_a.inst_mem_ack_in = 1'b0;
        step();
        chk("noack_valid", valid_a, 0);
        chk("noack_req", mem_a.inst_mem_req_out, 1);

        // Redirect while a request is outstanding; late response must vanish.
        select_new_pc = 1'b1;
        new_pc        = 32'h100;
        step();
        chk("drop_req", mem_a.inst_mem_req_out, 0);
        chk("drop_valid", valid_a, 0);
        select_new_pc = 1'b0;
        mem_a.inst_mem_ack_in  = 1'b1;
        mem_a.inst_mem_data_in = 32'hBAD0_BAD0;
        step();
        chk("drop_late_valid", valid_a, 0);
        chk("drop_next_req", mem_a.inst_mem_req_out, 1);
        chk("drop_next_addr", mem_a.inst_mem_addr_out, 32'h100);
        mem_a.inst_mem_data_in = 32'h1111_1111;
        step();
        chk("after_drop_valid", valid_a, 1);
        chk("after_drop_instr", instr_a, 32'h1111_1111);
        chk("after_drop_npc", npc_a, 32'h104);

        // Redirect with ack in the same cycle discards the word.
        select_new_pc = 1'b1;
        new_pc        = 32'h8;
        mem_a.inst_mem_data_in = 32'h2222_2222;
        step();
        chk("redir_ack_valid", valid_a, 0);
        chk("redir_ack_addr", mem_a.inst_mem_addr_out, 32'h8);

        // Stall with a captured word, ack during stall ignored.
        select_new_pc = 1'b0;
        en            = 1'b0;
        mem_a.inst_mem_data_in = 32'hDEAD_BEEF;
        step();
        chk("stall_req", mem_a.inst_mem_req_out, 0);
        chk("stall_valid", valid_a, 0);
        chk("stall_instr", instr_a, 32'h1111_1111);
        for (int k = 0; k < 2; k++) begin
            mem_a.inst_mem_ack_in  = (k == 0);
            mem_a.inst_mem_data_in = 32'h5555_5555;
            step();
            chk("stall_hold_req", mem_a.inst_mem_req_out, 0);
            chk("stall_hold_valid", valid_a, 0);
            chk("stall_hold_addr", mem_a.inst_mem_addr_out, 32'hC);
        end
        en = 1'b1;
        mem_a.inst_mem_ack_in = 1'b0;
        step();
        chk("unstall_valid", valid_a, 1);
        chk("unstall_instr", instr_a, 32'hDEAD_BEEF);
        chk("unstall_npc", npc_a, 32'hC);
        chk("unstall_req", mem_a.inst_mem_req_out, 1);

        // Redirect out of a stall loses the buffered word.
        en = 1'b0;
        mem_a.inst_mem_ack_in  = 1'b1;
        mem_a.inst_mem_data_in = 32'h3333_3333;
        step();
        chk("stall2_valid_held", valid_a, 1);
        chk("stall2_instr_held", instr_a, 32'hDEAD_BEEF);
        select_new_pc = 1'b1;
        new_pc        = 32'h40;
        mem_a.inst_mem_ack_in = 1'b0;
        step();
        chk("stall_redir_addr", mem_a.inst_mem_addr_out, 32'h40);
        chk("stall_redir_req", mem_a.inst_mem_req_out, 1);
        chk("stall_redir_valid", valid_a, 0);
        select_new_pc = 1'b0;
        en            = 1'b1;
        mem_a.inst_mem_ack_in  = 1'b1;
        mem_a.inst_mem_data_in = 32'h4444_4444;
        step();
        chk("stall_redir_instr", instr_a, 32'h4444_4444);
        chk("stall_redir_npc", npc_a, 32'h44);

        // Unaligned target is used unmodified.
        select_new_pc = 1'b1;
        new_pc        = 32'h103;
        step();
        chk("unaligned_addr", mem_a.inst_mem_addr_out, 32'h103);

        // PC wrap at the top of the address space.
        new_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap_pre_addr", mem_a.inst_mem_addr_out, 32'hFFFF_FFFC);
        select_new_pc = 1'b0;
        mem_a.inst_mem_data_in = 32'h6666_6666;
        step();
        chk("wrap_npc", npc_a, 32'h0);
        chk("wrap_valid", valid_a, 1);
        chk("wrap_addr", mem_a.inst_mem_addr_out, 32'h0);

        mem_a.inst_mem_ack_in = 1'b0;
        en = 1'b0;
        step();
        chk("hold_valid", valid_a, 1);
        chk("hold_instr", instr_a, 32'h6666_6666);

        // dut_b has been waiting in S_DROP since the first redirect; reset it there.
        chk("b_in_drop_req", mem_b.inst_mem_req_out, 0);
        en    = 1'b1;
        rst_n = 1'b0;
        step();
        chk("b_rst_valid", valid_b, 0);
        chk("b_rst_req", mem_b.inst_mem_req_out, 1);
        chk("b_rst_addr", mem_b.inst_mem_addr_out, 32'h200);
        chk("a_rst_valid", valid_a, 0);
        chk("a_rst_instr", instr_a, 0);
        chk("a_rst_npc", npc_a, 0);
        rst_n = 1'b1;
        mem_b.inst_mem_ack_in  = 1'b1;
        mem_b.inst_mem_data_in = 32'h7777_7777;
        step();
        chk("b_post_rst_valid", valid_b, 1);
        chk("b_post_rst_instr", instr_b, 32'h7777_7777);
        chk("b_post_rst_npc", npc_b, 32'h204);
        chk("b_post_rst_addr", mem_b.inst_mem_addr_out, 32'h204);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instruction_fetch
